// File: rtl/mult_share_ctrl.sv
// Round-robin sequencer sharing one add-shift multiplier between two requesters.
// Issues clr_ld, WIDTH add/shift pairs (last add pair subtracts), then a done pulse.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending requests
// LOAD  | clear accumulator, load operands for the granted requester
// ADD   | conditional add (sub on the final iteration) of multiplicand on M
// SHIFT | arithmetic right shift; advance iteration count or finish
// DONE  | pulse done to the granted requester, hand priority to the other one
module mult_share_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       M,
    output logic [1:0] grant,
    output logic       busy,
    output logic       clr_ld,
    output logic       add,
    output logic       sub,
    output logic       shift,
    output logic [1:0] done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ptr, ptr_nxt;
    logic [1:0]    grant_nxt;
    logic [1:0]    winner;

    // ptr=0 favours req[0] on a tie, ptr=1 favours req[1]
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = ptr ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 1'b0;
            grant <= 2'b00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            grant <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        clr_ld    = 1'b0;
        add       = 1'b0;
        sub       = 1'b0;
        shift     = 1'b0;
        done      = 2'b00;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = LOAD;
                    grant_nxt = winner;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                clr_ld    = 1'b1;
                state_nxt = ADD;
            end
            ADD: begin
                // add/sub follow M directly to line up with the datapath's LSB
                if (cnt == CNT_LAST) begin
                    sub = M;
                end else begin
                    add = M;
                end
                state_nxt = SHIFT;
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                    state_nxt = ADD;
                end
            end
            DONE: begin
                done      = grant;
                ptr_nxt   = grant[0];
                grant_nxt = 2'b00;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    assign busy = (state != IDLE);

    a_ctrl_exclusive: assert property (@(posedge clk)
        $onehot0({clr_ld, add, sub, shift, |done}));

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: table of transactions checked cycle by cycle,
// hand sequences for back-to-back, reset abort and request drop, plus a random phase.
module tb_mult_share_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic       M;
    logic [1:0] grant;
    logic       busy;
    logic       clr_ld;
    logic       add;
    logic       sub;
    logic       shift;
    logic [1:0] done;

    int n_checks = 0;
    int n_fail   = 0;

    mult_share_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .M      (M),
        .grant  (grant),
        .busy   (busy),
        .clr_ld (clr_ld),
        .add    (add),
        .sub    (sub),
        .shift  (shift),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [7:0] pat;
        logic [1:0] exp_grant;
    } vec_t;

    vec_t vecs[8];

    // {busy, grant[1:0], clr_ld, add, sub, shift, done[1:0]}
    function automatic logic [8:0] act();
        return {busy, grant, clr_ld, add, sub, shift, done};
    endfunction

    // Expected outputs for cycle i (1 = LOAD ... 18 = DONE) of a transaction
    function automatic logic [8:0] exp_out(int i, logic [7:0] pat, logic [1:0] g);
        logic [8:0] e;
        int k;
        e = {1'b1, g, 6'b000000};
        if (i == 1) begin
            e[5] = 1'b1;
        end else if (i <= 17 && (i % 2) == 0) begin
            k = (i - 2) / 2;
            if (k == 7) e[3] = pat[k];
            else        e[4] = pat[k];
        end else if (i <= 17) begin
            e[2] = 1'b1;
        end else begin
            e[1:0] = g;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [8:0] a, input logic [8:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (busy,grant,clr,add,sub,shift,done)", name, a, e);
        end
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        M = 1'($urandom);
        #1;
        check(name, act(), 9'b0);
    endtask

    // Drive one transaction from IDLE; optional request drop or reset abort at a cycle
    task automatic run_txn(input logic [1:0] r, input logic [7:0] pat, input logic [1:0] g,
                           input int drop_at, input int reset_at, input bit hold);
        req = r;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == drop_at) req = 2'b00;
            if (i >= 2 && i <= 16 && (i % 2) == 0) M = pat[(i - 2) / 2];
            else                                    M = 1'($urandom);
            #1;
            check($sformatf("txn req=%b pat=%h cyc%0d", r, pat, i), act(), exp_out(i, pat, g));
            if (i == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                #1;
                check($sformatf("after reset at cyc%0d", i), act(), 9'b0);
                reset = 1'b0;
                return;
            end
        end
        if (!hold) req = 2'b00;
    endtask

    initial begin
        bit pending;
        bit prev_busy;
        logic [1:0] prev_grant;

        reset = 1'b1;
        req   = 2'b00;
        M     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset state", act(), 9'b0);
        reset = 1'b0;
        idle_check("idle after reset");

        vecs[0] = '{2'b01, 8'hFF, 2'b01};
        vecs[1] = '{2'b10, 8'h00, 2'b10};
        vecs[2] = '{2'b11, 8'hA5, 2'b01};
        vecs[3] = '{2'b11, 8'h5A, 2'b10};
        vecs[4] = '{2'b10, 8'h81, 2'b10};
        vecs[5] = '{2'b11, 8'h7F, 2'b01};
        vecs[6] = '{2'b01, 8'h80, 2'b01};
        vecs[7] = '{2'b11, 8'h01, 2'b10};

        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].req, vecs[v].pat, vecs[v].exp_grant, 0, 0, 1'b0);
            idle_check($sformatf("gap after vec%0d", v));
        end

        // both requests held: grants alternate with one IDLE cycle between
        run_txn(2'b11, 8'hC3, 2'b01, 0, 0, 1'b1);
        idle_check("b2b gap1");
        run_txn(2'b11, 8'h3C, 2'b10, 0, 0, 1'b1);
        idle_check("b2b gap2");
        run_txn(2'b11, 8'hFF, 2'b01, 0, 0, 1'b0);
        idle_check("b2b end");

        // reset in 4th SHIFT (cycle 9): no done, ptr back to req[0], held req restarts
        run_txn(2'b11, 8'h55, 2'b10, 0, 9, 1'b1);
        run_txn(2'b11, 8'hAA, 2'b01, 0, 0, 1'b0);
        idle_check("after reset restart");

        // request dropped mid-transaction: runs to completion, no reload
        run_txn(2'b01, 8'h96, 2'b01, 5, 0, 1'b0);
        idle_check("drop idle1");
        idle_check("drop idle2");

        // random phase with protocol checker
        pending    = 1'b0;
        prev_busy  = 1'b0;
        prev_grant = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req   = 2'($urandom);
            M     = 1'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            #1;
            n_checks++;
            if (!$onehot0({clr_ld, add, sub, shift, |done}) || !$onehot0(done)) begin
                n_fail++;
                $display("FAIL rnd exclusive cyc%0d: got %b", c, act());
            end
            if (busy && prev_busy) begin
                n_checks++;
                if (grant !== prev_grant) begin
                    n_fail++;
                    $display("FAIL rnd grant stable cyc%0d: got %b expected %b", c, grant, prev_grant);
                end
            end
            if (done != 2'b00) begin
                n_checks++;
                if (!pending || done !== grant) begin
                    n_fail++;
                    $display("FAIL rnd done cyc%0d: got done=%b grant=%b pending=%0d expected done=grant with pending=1",
                             c, done, grant, pending);
                end
                pending = 1'b0;
            end
            if (clr_ld) begin
                n_checks++;
                if (pending) begin
                    n_fail++;
                    $display("FAIL rnd lost done cyc%0d: got pending=1 expected 0", c);
                end
                pending = 1'b1;
            end
            if (reset) pending = 1'b0;
            prev_busy  = busy;
            prev_grant = grant;
        end
        reset = 1'b0;
        req   = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
